binary_bcd: RTL and testbench



---
 rtl/binary_bcd_pkg.sv | 23 ++
 rtl/binary_bcd_sevseg.sv | 31 +++
 rtl/binary_bcd.sv | 63 ++++++
 tb/tb_binary_bcd.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/binary_bcd_pkg.sv
// Shared types and constants for the 4-bit binary to BCD converter.
// Seven-segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package binary_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  localparam bcd_digit_t BCD_BASE      = 4'd10;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/binary_bcd_sevseg.sv
// Combinational BCD digit to seven-segment decoder; blank_i forces all
// segments off. Only used when BINARY_BCD_SEVSEG_EN is defined.
module binary_bcd_sevseg
  import binary_bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives seg_o; no latch.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/binary_bcd.sv
// Registered 4-bit binary to BCD (units digit + tens flag), 1-cycle latency.
// Optional seven-segment output seg enabled by macro BINARY_BCD_SEVSEG_EN.
module binary_bcd
  import binary_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] y,
  output logic       tens,
  output logic       out_valid
`ifdef BINARY_BCD_SEVSEG_EN
  ,
  output logic [6:0] seg
`endif
);

  bcd_digit_t bin_value;
  bcd_digit_t y_d, y_q;
  logic       tens_d, tens_q;
  logic       valid_q;

  assign bin_value = {d, c, b, a};

  always_comb begin
    y_d    = bin_value;
    tens_d = 1'b0;
    if (bin_value > BCD_MAX_DIGIT) begin
      y_d    = bin_value - BCD_BASE;
      tens_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together.
    if (rst) begin
      y_q     <= '0;
      tens_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      tens_q  <= tens_d;
      valid_q <= 1'b1;
    end
  end

  assign y         = y_q;
  assign tens      = tens_q;
  assign out_valid = valid_q;

`ifdef BINARY_BCD_SEVSEG_EN
  // Decoded from registered state only, so seg follows y with no extra delay.
  binary_bcd_sevseg u_sevseg (
    .digit_i (y_q),
    .blank_i (!valid_q),
    .seg_o   (seg)
  );
`endif

endmodule

// File: tb/tb_binary_bcd.sv
// Directed self-checking bench for binary_bcd; seg checks are compiled in
// when BINARY_BCD_SEVSEG_EN is defined.
module tb_binary_bcd;

  logic       clk;
  logic       rst;
  logic       a, b, c, d;
  logic [3:0] y;
  logic       tens;
  logic       out_valid;
`ifdef BINARY_BCD_SEVSEG_EN
  logic [6:0] seg;
`endif

  int errors = 0;
  int checks = 0;

  binary_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .y         (y),
    .tens      (tens),
    .out_valid (out_valid)
`ifdef BINARY_BCD_SEVSEG_EN
    ,
    .seg       (seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Set inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic drive(input logic [3:0] n, input logic r);
    @(negedge clk);
    {d, c, b, a} = n;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ey,
                            input logic et, input logic ev);
    check({tag, ".y"}, {4'h0, y}, {4'h0, ey});
    check({tag, ".tens"}, {7'h0, tens}, {7'h0, et});
    check({tag, ".valid"}, {7'h0, out_valid}, {7'h0, ev});
  endtask

  // Hand-computed expected units digit and tens flag for N = 0..15.
  logic [3:0] exp_y    [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic       exp_tens [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1;
    {d, c, b, a} = 4'b1111;

    // Reset held for two edges with 1111 on the inputs.
    drive(4'b1111, 1'b1);
    expect_out("reset0", 4'd0, 1'b0, 1'b0);
`ifdef BINARY_BCD_SEVSEG_EN
    check("reset0.seg", {1'b0, seg}, 8'h00);
`endif
    drive(4'b1111, 1'b1);
    expect_out("reset1", 4'd0, 1'b0, 1'b0);

    // First edge with rst low converts 15.
    drive(4'b1111, 1'b0);
    expect_out("post_reset", 4'd5, 1'b1, 1'b1);
`ifdef BINARY_BCD_SEVSEG_EN
    check("seg_15", {1'b0, seg}, 8'h6D);
`endif

    // Exhaustive sweep, one value per cycle.
    for (int n = 0; n < 16; n++) begin
      drive(4'(n), 1'b0);
      expect_out($sformatf("sweep%0d", n), exp_y[n], exp_tens[n], 1'b1);
    end

    // Decade boundary back to back.
    drive(4'b1001, 1'b0);
    expect_out("dec9", 4'd9, 1'b0, 1'b1);
`ifdef BINARY_BCD_SEVSEG_EN
    check("seg_9", {1'b0, seg}, 8'h6F);
`endif
    drive(4'b1010, 1'b0);
    expect_out("dec10", 4'd0, 1'b1, 1'b1);

    // Zero is a valid conversion.
    drive(4'b0000, 1'b0);
    expect_out("zero", 4'd0, 1'b0, 1'b1);
`ifdef BINARY_BCD_SEVSEG_EN
    check("seg_0", {1'b0, seg}, 8'h3F);
`endif

    // Mid-stream reset discards the 1100 sample.
    drive(4'b0111, 1'b0);
    expect_out("mid_7", 4'd7, 1'b0, 1'b1);
    drive(4'b1100, 1'b1);
    expect_out("mid_rst", 4'd0, 1'b0, 1'b0);
`ifdef BINARY_BCD_SEVSEG_EN
    check("mid_rst.seg", {1'b0, seg}, 8'h00);
`endif
    drive(4'b0011, 1'b0);
    expect_out("mid_after", 4'd3, 1'b0, 1'b1);

    // Hold: toggle a between edges after 0101 has been sampled.
    drive(4'b0101, 1'b0);
    expect_out("hold_start", 4'd5, 1'b0, 1'b1);
`ifdef BINARY_BCD_SEVSEG_EN
    check("seg_5", {1'b0, seg}, 8'h6D);
`endif
    for (int i = 0; i < 3; i++) begin
      a = ~a;
      #1;
      check($sformatf("hold%0d.y", i), {4'h0, y}, 8'h05);
      check($sformatf("hold%0d.tens", i), {7'h0, tens}, 8'h00);
    end
    a = 1'b1;
    @(posedge clk);
    #1;
    check("hold_end.y", {4'h0, y}, 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
